sr_engine: RTL
==============

# sr_engine

Parametrised multi-mode shift engine and next-generation serial/parallel conversion block. It accepts commands through a valid/ready handshake and executes multi-cycle shift or rotate sequences of STEP bits per cycle. Supported modes are parallel load, logical shift, rotate and arithmetic shift, with a per-step serial output. It sits between serial link front-ends and parallel datapath logic, replacing the fixed single-bit shift register where width, step size, mode or step count must vary.

## Interface
- WIDTH, 8: register width in bits; WIDTH >= 2.
- STEP, 1: bits shifted per cycle; 1 <= STEP < WIDTH.
- COUNT_W, 4: width of the step-count field.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine can accept a command (high only in IDLE).
- cmd_op  input  3  SHIFT_OP from sr_pkg.
- cmd_count  input  COUNT_W  number of steps to execute.
- load_data  input  WIDTH  parallel load value (used by OP_LOAD).
- serial_in  input  STEP  fill bits, sampled on every executed step.
- data_out  output  WIDTH  current register contents.
- serial_out  output  STEP  bits shifted out by the most recent step.
- busy  output  1  high while in BUSY.
- done  output  1  one-cycle pulse when a command completes.

## Operation
- A command is accepted on any edge where cmd_valid && cmd_ready. On that edge op and count are latched into op_q and remaining.
- States:
  - IDLE → BUSY when a command is accepted with a shifting op and count > 0.
  - IDLE → IDLE with done when a command is accepted with OP_LOAD, count 0, or a reserved op.
  - BUSY → IDLE with done on the edge that executes the step where remaining == 1.
- OP_LOAD: data_out <= load_data on the acceptance edge. cmd_count is ignored and serial_out is unchanged.
- One step per BUSY cycle. Each step decrements remaining. data_out and serial_out update together on that edge.
- OP_SHL: data_out <= {data_out[WIDTH-STEP-1:0], serial_in}; serial_out <= data_out[WIDTH-1 -: STEP].
- OP_SHR: data_out <= {serial_in, data_out[WIDTH-1:STEP]}; serial_out <= data_out[STEP-1:0].
- OP_ROL and OP_ROR: same as SHL/SHR, but the fill comes from the bits shifted out. serial_out still reports the shifted-out bits. serial_in is ignored.
- OP_ASR: as SHR, but the fill is STEP copies of data_out[WIDTH-1].
- Reserved ops 6 and 7: no register change; done pulses as for count 0.
- Counts exceeding WIDTH/STEP are legal:
  - Logical shifts continue filling from serial_in.
  - Rotations wrap with period WIDTH/STEP when STEP divides WIDTH.
  - ASR saturates to all-sign.
- cmd_valid, cmd_op, cmd_count and load_data are don't-care while cmd_ready is low.

## Timing
- Reset values: data_out 0, serial_out 0, done 0, busy 0, state IDLE, cmd_ready 1.
- Command accepted at edge E0 with count N > 0:
  - Steps execute at edges E1..EN.
  - busy is high for cycles E0..EN-1 (N cycles).
  - done is high for exactly the cycle after EN.
- LOAD, count 0 and reserved ops: done is high in the cycle after E0 and busy never asserts.
- done and cmd_ready are both high in the completion cycle, so back-to-back commands are accepted with zero idle cycles.
- Asserting reset mid-operation aborts the command immediately. All outputs return to their reset values and no done is issued.
- serial_in is sampled on the step edge itself, not at acceptance.

## Structure
- sr_pkg holds shared definitions:
  - SHIFT_OP: 3-bit enum with OP_LOAD=0, OP_SHL=1, OP_SHR=2, OP_ROL=3, OP_ROR=4, OP_ASR=5.
  - SR_STATE enum: IDLE, BUSY.
  - Any shared localparams.
- sub-module sr_step: purely combinational single-step function (op, data, serial_in → next data, shifted-out bits), parametrised by WIDTH and STEP.
- sr_engine contains the FSM, remaining counter, handshake and output registers.

## Test plan
- Reset: with reset low, data_out=0, serial_out=0, done=0, busy=0 and cmd_ready=1; a command presented while reset is low is ignored.
- WIDTH=8, STEP=1; LOAD 0xA5, then SHL count 3 with serial_in=1 → data_out 0x4B, 0x97, 0x2F; serial_out 1, 0, 1; busy 3 cycles; done 1 cycle.
- LOAD 0x81, then ASR count 2 → data_out 0xC0, then 0xE0; serial_out 1, then 0.
- LOAD 0x3C, then ROR count 8 → data_out 0x3C at completion; busy exactly 8 cycles; a second command held on cmd_valid is accepted in the done cycle.
- SHL count 0 → data_out unchanged and done in the next cycle; reserved op 7 → same behaviour.
- STEP=2: LOAD 0xB4, then SHR count 2 with serial_in=2'b11 → 0xED, then 0xFB. Separately, assert reset after 1 step of a 4-step SHR → outputs 0 and no done.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the shift engine: operation codes, FSM states and
// a helper that classifies an opcode as a multi-cycle shifting operation.
package sr_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ASR  = 3'd5
  } shift_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sr_state_e;

  localparam int unsigned OP_W = 3;

  // True for opcodes that run one step per cycle (6 and 7 are reserved).
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op >= OP_SHL) && (op <= OP_ASR);
  endfunction

endpackage

// File: rtl/sr_step.sv
// Single combinational step of the shift engine: given the current register
// value, the operation and the fill bits, produce the next register value and
// the STEP bits that leave the register.
module sr_step
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] data,
  input  logic [STEP-1:0]  serial_in,
  output logic [WIDTH-1:0] data_nxt,
  output logic [STEP-1:0]  shift_out
);

  // Select the next register value and the bits shifted out for this op.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    data_nxt  = data;
    shift_out = '0;
    case (op)
      OP_SHL: begin
        data_nxt  = {data[WIDTH-STEP-1:0], serial_in};
        shift_out = data[WIDTH-1 -: STEP];
      end
      OP_SHR: begin
        data_nxt  = {serial_in, data[WIDTH-1:STEP]};
        shift_out = data[STEP-1:0];
      end
      OP_ROL: begin
        data_nxt  = {data[WIDTH-STEP-1:0], data[WIDTH-1 -: STEP]};
        shift_out = data[WIDTH-1 -: STEP];
      end
      OP_ROR: begin
        data_nxt  = {data[STEP-1:0], data[WIDTH-1:STEP]};
        shift_out = data[STEP-1:0];
      end
      OP_ASR: begin
        data_nxt  = {{STEP{data[WIDTH-1]}}, data[WIDTH-1:STEP]};
        shift_out = data[STEP-1:0];
      end
      default: begin
        data_nxt  = data;
        shift_out = '0;
      end
    endcase
  end

endmodule

// File: rtl/sr_engine.sv
// Multi-mode shift engine: accepts a command over valid/ready, then executes
// the requested number of shift/rotate steps, one per cycle, and pulses done.
module sr_engine
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STEP    = 1,
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0]   load_data,
  input  logic [STEP-1:0]    serial_in,
  output logic [WIDTH-1:0]   data_out,
  output logic [STEP-1:0]    serial_out,
  output logic               busy,
  output logic               done
);

  sr_state_e          state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [STEP-1:0]    serial_q, serial_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_data;
  logic [STEP-1:0]    step_out;

  sr_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .op        (op_q),
    .data      (data_q),
    .serial_in (serial_in),
    .data_nxt  (step_data),
    .shift_out (step_out)
  );

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      remaining_q <= '0;
      data_q      <= '0;
      serial_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: command acceptance in IDLE, one step per BUSY cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          remaining_d = cmd_count;
          if (cmd_op == OP_LOAD) begin
            data_d = load_data;
            done_d = 1'b1;
          end else if (is_shift_op(cmd_op) && (cmd_count != '0)) begin
            state_d = BUSY;
          end else begin
            // Count 0 or reserved op: complete immediately, register untouched.
            done_d = 1'b1;
          end
        end
      end
      BUSY: begin
        data_d      = step_data;
        serial_d    = step_out;
        remaining_d = remaining_q - COUNT_W'(1);
        if (remaining_q == COUNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == BUSY);
  assign done       = done_q;
  assign data_out   = data_q;
  assign serial_out = serial_q;

endmodule
